// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the execute (ex) and load (ld) writeback sources.
// Optional macro WB_ARB_RR_EN selects round-robin conflict resolution instead of ld-priority with starvation limit.
module wb_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [4:0]       ex_addr_i,
  input  logic [31:0]      ex_data_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [4:0]       ld_addr_i,
  input  logic [31:0]      ld_data_i,
  output logic [4:0]       rd_addr_o,
  output logic [31:0]      rd_data_o,
  output logic             rd_wr_en_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  logic        both;
  logic        ex_win;
  logic        ex_acc;
  logic        ld_acc;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign both = ex_valid_i & ld_valid_i;

`ifdef WB_ARB_RR_EN
  // Set when ex won the most recent conflict; reset value makes ld win the first conflict.
  logic last_ex;

  assign ex_win = both ? ~last_ex : ex_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ex <= 1'b1;
    end else if (both) begin
      last_ex <= ex_win;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign ex_win = both ? (starve_cnt == STARVE_LIM) : ex_valid_i;

  always_ff @(posedge clk) begin
    if (rst || !ex_valid_i || ex_acc) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  assign ex_acc     = ~rst & ex_valid_i & ex_win;
  assign ld_acc     = ~rst & ld_valid_i & ~ex_win;
  assign ex_ready_o = ex_acc;
  assign ld_ready_o = ld_acc;

  assign sel_addr = ex_acc ? ex_addr_i : ld_addr_i;
  assign sel_data = ex_acc ? ex_data_i : ld_data_i;

  // Writes to x0 complete the handshake but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_o  <= 5'd0;
      rd_data_o  <= 32'd0;
      rd_wr_en_o <= 1'b0;
    end else if ((ex_acc || ld_acc) && (sel_addr != 5'd0)) begin
      rd_addr_o  <= sel_addr;
      rd_data_o  <= sel_data;
      rd_wr_en_o <= 1'b1;
    end else begin
      rd_wr_en_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
    end else if (both && (conflict_cnt_o != {CNT_W{1'b1}})) begin
      conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (STARVE_MAX=4, CNT_W=4 so saturation is reachable).
// Expected grant patterns follow WB_ARB_RR_EN when the bench is built with it.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ld_valid;
  logic        ex_ready, ld_ready;
  logic [4:0]  ex_addr, ld_addr;
  logic [31:0] ex_data, ld_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wr_en;
  logic [3:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;
  int cnt_m  = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;

  wb_port_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_wr_en_o(rd_wr_en),
    .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One handshake cycle: drive valids, check readys, then check the write port and counter.
  task automatic cyc(input logic ev, input logic lv, input logic exp_ex, input string tag);
    logic exp_ld;
    logic wr;
    exp_ld   = lv & ~exp_ex;
    ex_valid = ev;
    ld_valid = lv;
    #1;
    chk({tag, " ex_ready"}, 32'(ex_ready), 32'(exp_ex & ev));
    chk({tag, " ld_ready"}, 32'(ld_ready), 32'(exp_ld));
    wr = 1'b0;
    if (exp_ex && ev && ex_addr != 5'd0) begin
      wr = 1'b1; m_addr = ex_addr; m_data = ex_data;
    end else if (exp_ld && ld_addr != 5'd0) begin
      wr = 1'b1; m_addr = ld_addr; m_data = ld_data;
    end
    if (ev && lv && cnt_m < 15) cnt_m++;
    @(posedge clk); #1;
    chk({tag, " wr_en"}, 32'(rd_wr_en), 32'(wr));
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'(m_addr));
    chk({tag, " rd_data"}, rd_data, m_data);
    chk({tag, " conflict_cnt"}, 32'(conflict_cnt), 32'(cnt_m));
    if (exp_ex && ev) ex_data = ex_data + 32'd1;
    if (exp_ld) ld_data = ld_data + 32'd1;
  endtask

  function automatic logic conflict_ex_wins(input int i);
`ifdef WB_ARB_RR_EN
    return (i % 2) == 1;
`else
    return (i % 5) == 4;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    ex_valid = 1'b1; ld_valid = 1'b1;
    ex_addr = 5'd7; ex_data = 32'hE000_0000;
    ld_addr = 5'd9; ld_data = 32'hA000_0000;

    // Reset held two cycles with both valids high.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst ex_ready", 32'(ex_ready), 32'd0);
      chk("rst ld_ready", 32'(ld_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst wr_en", 32'(rd_wr_en), 32'd0);
      chk("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
      chk("rst rd_addr", 32'(rd_addr), 32'd0);
    end
    rst = 1'b0;

    // Single ex write, then idle cycle.
    ex_addr = 5'd5; ex_data = 32'hDEADBEEF;
    cyc(1'b1, 1'b0, 1'b1, "ex_single");
    cyc(1'b0, 1'b0, 1'b0, "ex_idle");
    chk("ex_idle holds data", rd_data, 32'hDEADBEEF);

    // ld write to x0 is consumed without a write.
    ld_addr = 5'd0; ld_data = 32'h1234;
    cyc(1'b0, 1'b1, 1'b0, "ld_x0");

    // Continuous conflicts: grant pattern and counter saturation at 15.
    ex_addr = 5'd7; ld_addr = 5'd9;
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, conflict_ex_wins(i), $sformatf("conflict%0d", i));
    chk("cnt saturated", 32'(conflict_cnt), 32'd15);

    // Reset pulse mid-stream discards the pending write and clears the counter.
    rst = 1'b1;
    #1;
    chk("rst2 ex_ready", 32'(ex_ready), 32'd0);
    chk("rst2 ld_ready", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst2 wr_en", 32'(rd_wr_en), 32'd0);
    chk("rst2 conflict_cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0; cnt_m = 0; m_addr = 5'd0; m_data = 32'd0;

    // Starvation count clears while ex is not valid.
`ifdef WB_ARB_RR_EN
    cyc(1'b1, 1'b1, 1'b0, "clr0");
    cyc(1'b1, 1'b1, 1'b1, "clr1");
    cyc(1'b0, 1'b1, 1'b0, "clr2");
    cyc(1'b1, 1'b1, 1'b0, "clr3");
    cyc(1'b1, 1'b1, 1'b1, "clr4");
    cyc(1'b1, 1'b1, 1'b0, "clr5");
    cyc(1'b1, 1'b1, 1'b1, "clr6");
    cyc(1'b1, 1'b1, 1'b0, "clr7");
`else
    cyc(1'b1, 1'b1, 1'b0, "clr0");
    cyc(1'b1, 1'b1, 1'b0, "clr1");
    cyc(1'b0, 1'b1, 1'b0, "clr2");
    cyc(1'b1, 1'b1, 1'b0, "clr3");
    cyc(1'b1, 1'b1, 1'b0, "clr4");
    cyc(1'b1, 1'b1, 1'b0, "clr5");
    cyc(1'b1, 1'b1, 1'b0, "clr6");
    cyc(1'b1, 1'b1, 1'b1, "clr7");
`endif
    cyc(1'b0, 1'b0, 1'b0, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between two writeback sources: the execute-stage result (ex) and the load unit (ld). Each source uses a valid/ready handshake. One request per cycle is granted and registered onto the `rd_addr`/`rd_data`/`rd_wr_en` write port. The block also filters writes to x0, prevents starvation of the execute path, and counts port conflicts for performance monitoring.

## Interface

**Parameters**
- `STARVE_MAX`, default 4: consecutive lost conflicts after which ex is forced to win (fixed-priority mode only); legal range 1..15.
- `CNT_W`, default 16: width of the conflict counter.

**Ports**
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid_i` in 1: execute writeback request.
- `ex_ready_o` out 1: ex request accepted this cycle.
- `ex_addr_i` in 5: destination register of the ex request.
- `ex_data_i` in 32: write data of the ex request.
- `ld_valid_i` in 1: load writeback request.
- `ld_ready_o` out 1: ld request accepted this cycle.
- `ld_addr_i` in 5: destination register of the ld request.
- `ld_data_i` in 32: write data of the ld request.
- `rd_addr_o` out 5: write address to the register file.
- `rd_data_o` out 32: write data to the register file.
- `rd_wr_en_o` out 1: write enable to the register file.
- `conflict_cnt_o` out CNT_W: saturating count of cycles in which both sources were valid.

## Operation

**Handshake**
- A transfer occurs when `valid` and `ready` are both high in the same cycle.
- A requester holds `valid`, `addr` and `data` stable until it is accepted.
- `ready` is combinational from the valids and the arbitration state.
- At most one `ready` is high per cycle.
- A `ready` is never high while its `valid` is low or while `rst` is high.

**Grant rules**
- Only one source valid: that source is granted.
- Both valid (a conflict), fixed-priority mode: ld wins, unless `starve_cnt == STARVE_MAX`, in which case ex wins.
- `starve_cnt` behaviour:
  - Increments, saturating at `STARVE_MAX`, in each cycle where ex is valid but not granted.
  - Clears on an ex grant or when `ex_valid_i` is low.

**Output register**
- An accept with `addr != 0` loads `rd_addr_o`/`rd_data_o` and sets `rd_wr_en_o = 1` on the next cycle.
- Any other cycle drives `rd_wr_en_o = 0`; `rd_addr_o`/`rd_data_o` hold their previous values.
- Accepting a request with `addr == 0` consumes it (handshake completes), but no write is issued.

**Ordering and counting**
- When both sources target the same register, write order equals grant order. The block performs no merging or reordering.
- `conflict_cnt_o` increments every cycle in which both valids are high and saturates at all-ones. Conflicts are counted regardless of addresses, including x0.

**Reset values**
- `rd_addr_o = 0`, `rd_data_o = 0`, `rd_wr_en_o = 0`, `conflict_cnt_o = 0`.
- `starve_cnt = 0`; the round-robin pointer is set so that ld wins next.

## Timing

- Latency: accept in cycle N, write port active in cycle N+1. The register file captures the write at the end of N+1, so a read returns the new value from N+2.
- Throughput: one write per cycle, sustained.
- Each accept produces exactly one cycle of `rd_wr_en_o`.
- The losing source waits at least one cycle. In fixed-priority mode ex waits at most `STARVE_MAX` cycles.
- Reset mid-operation: a write sitting in the output register is discarded (`rd_wr_en_o = 0` the cycle after `rst`). Requesters re-present their requests after reset.
- When `valid` falls without an accept, the request is abandoned and no state changes beyond clearing `starve_cnt`.

## Configuration

- `WB_ARB_RR_EN` defined: conflicts are resolved round-robin.
  - A one-bit pointer records the most recent conflict winner; the other source wins the next conflict.
  - The pointer updates only on conflict cycles.
  - `starve_cnt` and `STARVE_MAX` are unused.
- `WB_ARB_RR_EN` undefined: fixed priority (ld over ex) with the starvation limit, as described in Operation.

## Test plan

1. **Reset:** hold `rst` for 2 cycles with both valids high → both readys 0, `rd_wr_en_o = 0`, `conflict_cnt_o` stays 0 during reset.
2. **Single ex write:** ex only, `addr = 5`, `data = 0xDEADBEEF` in cycle N → `ex_ready_o = 1` in N; in N+1 `rd_wr_en_o = 1`, `rd_addr_o = 5`, `rd_data_o = 0xDEADBEEF`; in N+2 `rd_wr_en_o = 0`.
3. **x0 filter:** ld only, `addr = 0`, `data = 0x1234` → `ld_ready_o = 1`, and `rd_wr_en_o` stays 0 the next cycle.
4. **Fixed priority with starvation,** `STARVE_MAX = 4`, both valid continuously → grant pattern ld, ld, ld, ld, ex, repeating; `conflict_cnt_o` increments every cycle.
5. **Round-robin** (`WB_ARB_RR_EN` defined), both valid continuously from reset → grants ld, ex, ld, ex; writes appear in the same order one cycle later.
6. **Counter saturation,** `CNT_W = 4`: 20 consecutive conflict cycles → `conflict_cnt_o = 15` and it holds there; a `rst` pulse returns it to 0.
